// File: rtl/tiny_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tiny_arb_pkg
// Shared types and default sizes for the two-requester round-robin write
// arbiter (tiny_rr_arbiter) and its forward register (tiny_fwd_reg).
//   arb_state_e        : arbiter FSM state (idle / a requester holds the grant)
//   DEFAULT_DW/AW      : default data and address widths
//   DEFAULT_MAX_BURST  : default number of back-to-back beats one requester
//                        may take while the other one is waiting
// ---------------------------------------------------------------------------
package tiny_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DW        = 32;
  localparam int DEFAULT_AW        = 32;
  localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/tiny_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// tiny_rr_arbiter_if
// One valid/ready write channel carrying a data word and an address.
//   valid  : producer has a beat
//   ready  : consumer takes the beat when valid & ready
//   data   : write data  (DW bits)
//   addr   : write address (AW bits)
// Modports:
//   master : the side that produces beats (drives valid/data/addr)
//   slave  : the side that consumes beats (drives ready)
// ---------------------------------------------------------------------------
interface tiny_rr_arbiter_if
  import tiny_arb_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;

  modport master (output valid, output data, output addr, input ready);
  modport slave  (input valid, input data, input addr, output ready);

endinterface

// File: rtl/tiny_rr_arbiter_fwd_reg.sv
// ---------------------------------------------------------------------------
// tiny_fwd_reg
// Single-entry registered output stage of the arbiter. A beat presented on
// in_* is captured whenever the stage can take it (out_free) and shows up on
// m_* one cycle later. Supports a drain and a load in the same cycle, so a
// continuously ready consumer sees one beat per cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid          : a granted requester is offering a beat
//   in_data/in_addr   : beat payload
//   in_src            : which requester the beat comes from
//   out_free          : stage can take a beat this cycle (~m_valid | m_ready)
//   m_valid/m_ready   : downstream handshake
//   m_data/m_addr     : registered payload
//   m_src             : registered source index
// ---------------------------------------------------------------------------
module tiny_fwd_reg
  import tiny_arb_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_addr,
  input  logic          in_src,
  output logic          out_free,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_addr,
  output logic          m_src
);

  logic load;

  assign out_free = ~m_valid | m_ready;
  assign load     = in_valid & out_free;

  // Output register: a load always wins (it also covers a same-cycle drain),
  // otherwise a consumed beat empties the stage. The payload is left as-is
  // when nothing is loaded so m_* stay stable while the consumer stalls.
  // Reset throws away whatever beat is still sitting here.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_addr  <= '0;
      m_src   <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= in_data;
      m_addr  <= in_addr;
      m_src   <= in_src;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tiny_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tiny_rr_arbiter
// Lets two requesters (s0, s1) share one downstream write port. Grants are
// round-robin; a requester keeps the grant for at most MAX_BURST accepted
// beats while the other one is waiting, and keeps it indefinitely when there
// is no competitor. Entering a grant from idle costs one bubble cycle; after
// that the output stage runs at one beat per cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   s0, s1    : requester channels (slave side: we drive ready)
//   m         : downstream channel (master side: registered valid/data/addr)
//   m_src     : source of the beat currently on m (0 = s0, 1 = s1)
// ---------------------------------------------------------------------------
module tiny_rr_arbiter
  import tiny_arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int DW        = DEFAULT_DW,
  parameter int AW        = DEFAULT_AW
) (
  input  logic             clk,
  input  logic             rst,
  tiny_rr_arbiter_if.slave  s0,
  tiny_rr_arbiter_if.slave  s1,
  tiny_rr_arbiter_if.master m,
  output logic             m_src
);

  localparam int            CW        = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          sel_valid;
  logic          other_valid;
  logic [DW-1:0] sel_data;
  logic [AW-1:0] sel_addr;
  logic          grant_valid;
  logic          out_free;
  logic          accept;

  // Request muxing: "sel" is the requester holding the grant, "other" is
  // the one that would take over on a switch.
  assign sel_valid   = gnt_q ? s1.valid : s0.valid;
  assign other_valid = gnt_q ? s0.valid : s1.valid;
  assign sel_data    = gnt_q ? s1.data  : s0.data;
  assign sel_addr    = gnt_q ? s1.addr  : s0.addr;
  assign grant_valid = (state_q == ARB_GRANT) && sel_valid;
  assign accept      = grant_valid && out_free;

  // Arbiter state register. last starts at 1 so the very first tie after
  // reset goes to s0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic. In GRANT the checks are ordered: a withdrawn request
  // gives the grant away (or drops to idle) before anything else; the last
  // beat of a burst hands over only if the other side is actually waiting;
  // any other accepted beat just counts; a stalled output freezes everything.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (s0.valid || s1.valid) begin
          state_d    = ARB_GRANT;
          gnt_d      = (s0.valid && s1.valid) ? ~last_q : s1.valid;
          beat_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (!sel_valid) begin
          last_d = gnt_q;
          if (other_valid) begin
            gnt_d      = ~gnt_q;
            beat_cnt_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (accept && (beat_cnt_q == LAST_BEAT)) begin
          beat_cnt_d = '0;
          if (other_valid) begin
            gnt_d  = ~gnt_q;
            last_d = gnt_q;
          end
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Ready outputs: only the granted requester sees ready, and only when the
  // output stage can take its beat. Never asserted in idle, which is what
  // creates the single arbitration bubble.
  always_comb begin
    s0.ready = 1'b0;
    s1.ready = 1'b0;
    if ((state_q == ARB_GRANT) && out_free) begin
      s0.ready = ~gnt_q;
      s1.ready = gnt_q;
    end
  end

  tiny_fwd_reg #(
    .DW (DW),
    .AW (AW)
  ) u_fwd_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (grant_valid),
    .in_data  (sel_data),
    .in_addr  (sel_addr),
    .in_src   (gnt_q),
    .out_free (out_free),
    .m_valid  (m.valid),
    .m_ready  (m.ready),
    .m_data   (m.data),
    .m_addr   (m.addr),
    .m_src    (m_src)
  );

endmodule

// File: tb/tb_tiny_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tiny_rr_arbiter
// Self-checking bench for tiny_rr_arbiter. A behavioural model (owner,
// beats served in the current burst, last winner, a one-slot output queue)
// predicts the ready lines and the m_* outputs every cycle. Directed phases
// walk through the interesting arbitration cases, then a long randomized
// phase with random valids, withdrawals, back-pressure and resets follows.
// ---------------------------------------------------------------------------
module tb_tiny_rr_arbiter;

  localparam int MAX_BURST = 4;
  localparam int DW        = 32;
  localparam int AW        = 32;

  typedef enum {MODE_FORCED, MODE_RANDOM} stim_mode_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          src;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_src;

  tiny_rr_arbiter_if #(.DW(DW), .AW(AW)) s0_bus ();
  tiny_rr_arbiter_if #(.DW(DW), .AW(AW)) s1_bus ();
  tiny_rr_arbiter_if #(.DW(DW), .AW(AW)) m_bus ();

  tiny_rr_arbiter #(
    .MAX_BURST (MAX_BURST),
    .DW        (DW),
    .AW        (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s0    (s0_bus),
    .s1    (s1_bus),
    .m     (m_bus),
    .m_src (m_src)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Stimulus state: what each requester currently offers and m_ready.
  logic          req_valid [2];
  logic [DW-1:0] req_data  [2];
  logic [AW-1:0] req_addr  [2];
  logic          mr_drv;
  stim_mode_e    mode;
  logic          force_valid [2];
  logic          force_ready;

  // Reference model state.
  bit    mdl_idle;
  int    mdl_owner;
  int    mdl_last;
  int    mdl_served;
  beat_t mdl_slot[$];
  beat_t mdl_held;
  int    acc_who;

  int   vectors;
  int   miscompares;
  bit   log_en;
  logic log_src[$];

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    s0_bus.valid = req_valid[0];
    s0_bus.data  = req_data[0];
    s0_bus.addr  = req_addr[0];
    s1_bus.valid = req_valid[1];
    s1_bus.data  = req_data[1];
    s1_bus.addr  = req_addr[1];
    m_bus.ready  = mr_drv;
  endtask

  task automatic newBeat(input int x);
    req_data[x] = $urandom;
    req_addr[x] = $urandom;
  endtask

  task automatic setForce(input logic v0, input logic v1, input logic mr);
    mode = MODE_FORCED;
    force_valid[0] = v0;
    force_valid[1] = v1;
    force_ready    = mr;
    for (int x = 0; x < 2; x++) begin
      if (force_valid[x] && !req_valid[x]) newBeat(x);
      req_valid[x] = force_valid[x];
    end
    mr_drv = mr;
  endtask

  task automatic modelReset();
    mdl_idle   = 1'b1;
    mdl_owner  = 0;
    mdl_last   = 1;
    mdl_served = 0;
    mdl_slot.delete();
    mdl_held   = '0;
    acc_who    = -1;
  endtask

  // Expected outputs for the current cycle, compared with the DUT.
  task automatic compareAll();
    bit free;
    free = (mdl_slot.size() == 0) || mr_drv;
    checkOutput("s0_ready", s0_bus.ready, !mdl_idle && (mdl_owner == 0) && free);
    checkOutput("s1_ready", s1_bus.ready, !mdl_idle && (mdl_owner == 1) && free);
    checkOutput("m_valid",  m_bus.valid,  mdl_slot.size() != 0);
    checkOutput("m_data",   m_bus.data,   mdl_held.data);
    checkOutput("m_addr",   m_bus.addr,   mdl_held.addr);
    checkOutput("m_src",    m_src,        mdl_held.src);
    if (log_en && m_bus.valid && m_bus.ready) log_src.push_back(m_src);
  endtask

  // Advance the model by one clock using the inputs that were applied.
  task automatic modelStep();
    bit    free;
    beat_t b;
    beat_t dropped;
    int    other;
    acc_who = -1;
    if (rst) begin
      modelReset();
      return;
    end
    free = (mdl_slot.size() == 0) || mr_drv;
    if (!mdl_idle && req_valid[mdl_owner] && free) acc_who = mdl_owner;
    if ((mdl_slot.size() != 0) && mr_drv) dropped = mdl_slot.pop_front();
    if (acc_who >= 0) begin
      b.data = req_data[acc_who];
      b.addr = req_addr[acc_who];
      b.src  = (acc_who == 1);
      mdl_slot.push_back(b);
      mdl_held = b;
    end
    other = 1 - mdl_owner;
    if (mdl_idle) begin
      if (req_valid[0] || req_valid[1]) begin
        mdl_idle   = 1'b0;
        mdl_served = 0;
        if (req_valid[0] && req_valid[1]) mdl_owner = 1 - mdl_last;
        else                              mdl_owner = req_valid[1] ? 1 : 0;
      end
    end else if (!req_valid[mdl_owner]) begin
      mdl_last = mdl_owner;
      if (req_valid[other]) begin
        mdl_owner  = other;
        mdl_served = 0;
      end else begin
        mdl_idle = 1'b1;
      end
    end else if (acc_who >= 0) begin
      mdl_served++;
      if (mdl_served == MAX_BURST) begin
        mdl_served = 0;
        if (req_valid[other]) begin
          mdl_last  = mdl_owner;
          mdl_owner = other;
        end
      end
    end
  endtask

  // Requester / consumer behaviour for the next cycle. Payload only changes
  // after an accept or while valid is low, so held beats stay stable.
  task automatic updateRequests();
    for (int x = 0; x < 2; x++) begin
      if (acc_who == x) begin
        newBeat(x);
        req_valid[x] = (mode == MODE_RANDOM) ? ($urandom_range(3) != 0) : force_valid[x];
      end else if (mode == MODE_RANDOM) begin
        if (req_valid[x]) begin
          if ($urandom_range(15) == 0) req_valid[x] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          newBeat(x);
          req_valid[x] = 1'b1;
        end
      end else begin
        if (force_valid[x] && !req_valid[x]) newBeat(x);
        req_valid[x] = force_valid[x];
      end
    end
    mr_drv = (mode == MODE_RANDOM) ? ($urandom_range(3) != 0) : force_ready;
  endtask

  // One clock: drive at the falling edge, check just after, step at the rise.
  task automatic runCycle();
    applyStimulus();
    #1;
    compareAll();
    @(posedge clk);
    modelStep();
    updateRequests();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
  endtask

  initial begin
    int s0_beats;
    vectors     = 0;
    miscompares = 0;
    log_en      = 1'b0;
    for (int x = 0; x < 2; x++) begin
      req_valid[x]   = 1'b0;
      req_data[x]    = '0;
      req_addr[x]    = '0;
      force_valid[x] = 1'b0;
    end
    mr_drv      = 1'b0;
    force_ready = 1'b0;
    mode        = MODE_FORCED;
    applyStimulus();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    modelReset();
    rst = 1'b0;

    // Single requester, first beat after reset.
    $display("[TB] phase 1: single s0 beat after reset");
    setForce(1'b1, 1'b0, 1'b1);
    req_data[0] = 32'hA5A5_0001;
    req_addr[0] = 32'h0000_0010;
    runCycle();
    checkOutput("t1_s0_ready_c2", s0_bus.ready, 1'b1);
    checkOutput("t1_m_valid_c2",  m_bus.valid,  1'b0);
    runCycle();
    checkOutput("t1_m_valid", m_bus.valid, 1'b1);
    checkOutput("t1_m_src",   m_src,       1'b0);
    checkOutput("t1_m_data",  m_bus.data,  32'hA5A5_0001);
    checkOutput("t1_m_addr",  m_bus.addr,  32'h0000_0010);
    setForce(1'b0, 1'b0, 1'b1);
    repeat (3) runCycle();

    // Both requesters busy: bursts of MAX_BURST alternate.
    $display("[TB] phase 2: both requesters continuously valid");
    setForce(1'b1, 1'b1, 1'b1);
    doReset();
    log_src.delete();
    log_en = 1'b1;
    repeat (20) runCycle();
    log_en = 1'b0;
    checkOutput("t2_beats", log_src.size(), 18);
    for (int i = 0; i < 12 && i < log_src.size(); i++)
      checkOutput($sformatf("t2_src%0d", i), log_src[i], (i / MAX_BURST) % 2);

    // Downstream stall, then full throughput on release.
    $display("[TB] phase 4: downstream back-pressure");
    setForce(1'b1, 1'b1, 1'b0);
    repeat (5) runCycle();
    checkOutput("t4_ready_stalled", {s0_bus.ready, s1_bus.ready}, 2'b00);
    checkOutput("t4_m_valid_stalled", m_bus.valid, 1'b1);
    setForce(1'b1, 1'b1, 1'b1);
    log_src.delete();
    log_en = 1'b1;
    repeat (10) runCycle();
    log_en = 1'b0;
    checkOutput("t4_throughput", log_src.size(), 10);

    // Lone requester s1, back-to-back beats.
    $display("[TB] phase 3: s1 alone");
    setForce(1'b0, 1'b1, 1'b1);
    doReset();
    log_src.delete();
    log_en = 1'b1;
    repeat (12) runCycle();
    log_en = 1'b0;
    checkOutput("t3_beats", log_src.size(), 10);
    for (int i = 0; i < log_src.size(); i++)
      checkOutput($sformatf("t3_src%0d", i), log_src[i], 1'b1);

    // s0 withdraws mid-burst while s1 waits.
    $display("[TB] phase 5: mid-burst withdrawal");
    setForce(1'b1, 1'b0, 1'b1);
    doReset();
    runCycle();
    setForce(1'b1, 1'b1, 1'b1);
    s0_beats = 0;
    for (int c = 0; c < 20 && s0_beats < 2; c++) begin
      runCycle();
      if (acc_who == 0) s0_beats++;
    end
    checkOutput("t5_s0_beats", s0_beats, 2);
    setForce(1'b0, 1'b1, 1'b1);
    runCycle();
    checkOutput("t5_s1_ready", s1_bus.ready, 1'b1);
    checkOutput("t5_s0_ready", s0_bus.ready, 1'b0);
    repeat (6) runCycle();

    // Reset with a beat stuck in the output stage.
    $display("[TB] phase 6: reset with pending beat");
    setForce(1'b1, 1'b1, 1'b0);
    repeat (4) runCycle();
    checkOutput("t6_m_valid_before", m_bus.valid, 1'b1);
    doReset();
    checkOutput("t6_m_valid", m_bus.valid, 1'b0);
    checkOutput("t6_ready",   {s0_bus.ready, s1_bus.ready}, 2'b00);
    checkOutput("t6_m_data",  m_bus.data, 32'h0);
    setForce(1'b1, 1'b1, 1'b1);
    runCycle();
    checkOutput("t6_first_s0_ready", s0_bus.ready, 1'b1);
    checkOutput("t6_first_s1_ready", s1_bus.ready, 1'b0);

    // Randomized traffic with occasional resets.
    $display("[TB] phase 7: random traffic");
    mode = MODE_RANDOM;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(399) == 0);
      runCycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
